// File: rtl/inst_loader.sv
// inst_loader: write side of the instruction memory.
// Accepts a byte stream over valid/ready, assembles little-endian 32-bit
// instructions and issues one-cycle word writes at byte addresses
// BASE_ADDR + 4*index. Used to program code before the core leaves reset.
// Optional feature macro: INST_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte after the last word (CHECK state, chk_err flag).
// INST_SIZE must stay 32: four bytes are assembled per instruction.
module inst_loader #(
  parameter int unsigned     SIZE      = 1024,
  parameter int unsigned     WORD      = 32,
  parameter int unsigned     INST_SIZE = 32,
  parameter logic [WORD-1:0] BASE_ADDR = {WORD{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [15:0]          num_words,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [WORD-1:0]      mem_addr,
  output logic [INST_SIZE-1:0] mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 chk_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
`ifdef INST_LOADER_CHECKSUM_EN
  localparam logic [1:0] ST_CHECK = 2'd3;

  // Running checksum: XOR of every data byte of the current load.
  function automatic logic [7:0] csum_upd(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  logic [1:0]           state_r;
  logic [15:0]          len_r;
  logic [15:0]          widx_r;
  logic [1:0]           bcnt_r;
  logic [23:0]          word_r;
  logic                 mem_we_r;
  logic [WORD-1:0]      mem_addr_r;
  logic [INST_SIZE-1:0] mem_wdata_r;
  logic                 done_r;
  logic                 err_r;
`ifdef INST_LOADER_CHECKSUM_EN
  logic                 chk_err_r;
  logic [7:0]           csum_r;
`endif

  logic                 in_ready_s;
  logic                 accept_s;
  logic                 last_word_s;
  logic                 len_bad_s;
  logic [WORD-1:0]      wr_addr_s;

  // Decode handshake readiness from the current state.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_RECV:  in_ready_s = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
      ST_CHECK: in_ready_s = 1'b1;
`endif
      default:  in_ready_s = 1'b0;
    endcase
  end

  assign accept_s    = in_valid & in_ready_s;
  assign last_word_s = (widx_r == (len_r - 16'd1));
  assign len_bad_s   = (num_words == 16'd0) || (32'(num_words) > SIZE);
  assign wr_addr_s   = BASE_ADDR + (WORD'(widx_r) << 2);

  // Load sequencer: length check, byte assembly, word write, optional checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      len_r       <= 16'd0;
      widx_r      <= 16'd0;
      bcnt_r      <= 2'd0;
      word_r      <= 24'd0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {WORD{1'b0}};
      mem_wdata_r <= {INST_SIZE{1'b0}};
      done_r      <= 1'b0;
      err_r       <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      chk_err_r   <= 1'b0;
      csum_r      <= 8'd0;
`endif
    end else begin
      mem_we_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            chk_err_r <= 1'b0;
            csum_r    <= 8'd0;
`endif
            if (len_bad_s) begin
              err_r  <= 1'b1;
              done_r <= 1'b1;
            end else begin
              len_r   <= num_words;
              widx_r  <= 16'd0;
              bcnt_r  <= 2'd0;
              state_r <= ST_RECV;
            end
          end
        end
        ST_RECV: begin
          if (accept_s) begin
            bcnt_r <= bcnt_r + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_r <= csum_upd(csum_r, in_data);
`endif
            case (bcnt_r)
              2'd0: word_r[7:0]   <= in_data;
              2'd1: word_r[15:8]  <= in_data;
              2'd2: word_r[23:16] <= in_data;
              default: begin
                mem_we_r    <= 1'b1;
                mem_addr_r  <= wr_addr_s;
                mem_wdata_r <= {in_data, word_r};
                state_r     <= ST_WRITE;
              end
            endcase
          end
        end
        ST_WRITE: begin
          if (last_word_s) begin
`ifdef INST_LOADER_CHECKSUM_EN
            state_r <= ST_CHECK;
`else
            state_r <= ST_IDLE;
            done_r  <= 1'b1;
`endif
          end else begin
            widx_r  <= widx_r + 16'd1;
            state_r <= ST_RECV;
          end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept_s) begin
            if (csum_upd(csum_r, in_data) != 8'd0) begin
              chk_err_r <= 1'b1;
            end
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
`endif
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign busy      = (state_r != ST_IDLE);
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign done      = done_r;
  assign err       = err_r;
`ifdef INST_LOADER_CHECKSUM_EN
  assign chk_err   = chk_err_r;
`else
  assign chk_err   = 1'b0;
`endif

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader with a queue-based reference model.
`timescale 1ns/1ps
module tb_inst_loader;
  localparam int unsigned SIZE      = 16;
  localparam int unsigned WORD      = 32;
  localparam int unsigned INST_SIZE = 32;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_words;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        chk_err;

  int total = 0;
  int bad   = 0;

  logic [7:0]  stim[$];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];

  inst_loader #(
    .SIZE(SIZE), .WORD(WORD), .INST_SIZE(INST_SIZE), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  // Record every memory write seen between clock edges.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
    end
  end

  // Reference model: word i lives at BASE + 4*i, bytes little-endian.
  function automatic logic [31:0] model_addr(input int i);
    return BASE_ADDR + 32'(4 * i);
  endfunction

  function automatic logic [31:0] model_data(input int i);
    logic [31:0] v;
    v = 32'd0;
    for (int k = 3; k >= 0; k--) v = v * 32'd256 + 32'(stim[4*i+k]);
    return v;
  endfunction

  function automatic logic [7:0] model_csum();
    logic [7:0] c;
    c = 8'h00;
    foreach (stim[j]) c = c ^ stim[j];
    return c;
  endfunction

  task automatic fill_random(input int n);
    stim.delete();
    for (int j = 0; j < 4 * n; j++) stim.push_back(8'($urandom));
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
  endtask

  task automatic pulse_start(input logic [15:0] n);
    start     = 1'b1;
    num_words = n;
    @(negedge clk);
    start     = 1'b0;
    num_words = 16'($urandom);
  endtask

  // Offer one byte after 'gap' idle cycles; returns at the negedge after it is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL byte_accept_timeout: in_ready=%b required=1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL done_timeout: done=%b required=1", done);
    end
  endtask

  task automatic run_load(input int n, input int gap_max);
    clear_obs();
    pulse_start(16'(n));
    foreach (stim[j]) send_byte(stim[j], $urandom_range(gap_max, 0));
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(model_csum(), 0);
`endif
    wait_done();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; num_words = 16'd0; in_data = 8'd0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, chk_err} !== 71'd0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b chk=%b required all 0",
               in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, chk_err);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b rdy=%b we=%b required 0", busy, in_ready, mem_we);
    end
  endtask

  task automatic test_basic();
    stim = '{8'h13, 8'h05, 8'h00, 8'h91, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    clear_obs();
    pulse_start(16'd2);
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL start_response: busy=%b rdy=%b done=%b err=%b required 1 1 0 0", busy, in_ready, done, err);
    end
    for (int j = 0; j < 4; j++) send_byte(stim[j], 0);
    total++;
    if (mem_we !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL write_strobe: we=%b rdy=%b required 1 0", mem_we, in_ready);
    end
    for (int j = 4; j < 8; j++) send_byte(stim[j], 0);
    total++;
    if (mem_we !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL last_write: we=%b done=%b required 1 0", mem_we, done);
    end
    @(negedge clk);
`ifdef INST_LOADER_CHECKSUM_EN
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL check_state: busy=%b rdy=%b done=%b required 1 1 0", busy, in_ready, done);
    end
    send_byte(model_csum(), 0);
`endif
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || chk_err !== 1'b0) begin
      bad++;
      $display("FAIL basic_done: done=%b busy=%b err=%b chk=%b required 1 0 0 0", done, busy, err, chk_err);
    end
    total++;
    if (obs_addr.size() != 2) begin
      bad++;
      $display("FAIL basic_count: writes=%0d required=2", obs_addr.size());
    end else if (obs_data[0] !== 32'h9100_0513 || obs_data[1] !== 32'hDEAD_BEEF ||
                 obs_data[0] !== model_data(0) || obs_addr[0] !== model_addr(0) ||
                 obs_addr[1] !== model_addr(1)) begin
      bad++;
      $display("FAIL basic_words: %h@%h %h@%h required 91000513@%h deadbeef@%h",
               obs_data[0], obs_addr[0], obs_data[1], obs_addr[1], model_addr(0), model_addr(1));
    end
    total++;
    if (mem_addr !== model_addr(1) || mem_wdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL hold_last: addr=%h data=%h required %h deadbeef", mem_addr, mem_wdata, model_addr(1));
    end
  endtask

  task automatic test_illegal();
    logic [15:0] n;
    for (int r = 0; r < 2; r++) begin
      n = (r == 0) ? 16'd0 : 16'(SIZE + 1);
      clear_obs();
      pulse_start(n);
      total++;
      if (err !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL illegal_len_%0d: err=%b done=%b busy=%b rdy=%b required 1 1 0 0", n, err, done, busy, in_ready);
      end
      repeat (3) @(negedge clk);
      total++;
      if (obs_addr.size() != 0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL illegal_nowrite_%0d: writes=%0d busy=%b required 0 0", n, obs_addr.size(), busy);
      end
    end
  endtask

  task automatic test_stall();
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_not_ready: rdy=%b required=0", in_ready);
    end
    in_valid = 1'b0;
    fill_random(3);
    clear_obs();
    pulse_start(16'd3);
    total++;
    if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL flags_cleared: err=%b done=%b busy=%b required 0 0 1", err, done, busy);
    end
    for (int j = 0; j < 12; j++) begin
      send_byte(stim[j], 1);
      if (j == 5) begin
        start     = 1'b1;
        num_words = 16'd1;
        @(negedge clk);
        start     = 1'b0;
      end
    end
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(model_csum(), 1);
`endif
    wait_done();
    total++;
    if (obs_addr.size() != 3) begin
      bad++;
      $display("FAIL stall_count: writes=%0d required=3", obs_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs_addr[i] !== model_addr(i) || obs_data[i] !== model_data(i)) begin
          bad++;
          $display("FAIL stall_word%0d: %h@%h required %h@%h", i, obs_data[i], obs_addr[i], model_data(i), model_addr(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    fill_random(2);
    clear_obs();
    pulse_start(16'd2);
    for (int j = 0; j < 6; j++) send_byte(stim[j], 0);
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, chk_err} !== 71'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs: rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b chk=%b required all 0",
               in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, chk_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (obs_addr.size() != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_writes: writes=%0d busy=%b required 1 0", obs_addr.size(), busy);
    end
    fill_random(1);
    run_load(1, 0);
    total++;
    if (obs_addr.size() != 1 || obs_addr[0] !== model_addr(0) || obs_data[0] !== model_data(0)) begin
      bad++;
      $display("FAIL reload_after_reset: writes=%0d first=%h@%h required %h@%h",
               obs_addr.size(), obs_data[0], obs_addr[0], model_data(0), model_addr(0));
    end
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(5, 1);
      fill_random(n);
      run_load(n, 2);
      total++;
      if (obs_addr.size() != n || err !== 1'b0 || chk_err !== 1'b0) begin
        bad++;
        $display("FAIL rand_count_%0d: writes=%0d err=%b chk=%b required %0d 0 0", r, obs_addr.size(), err, chk_err, n);
      end else begin
        for (int i = 0; i < n; i++) begin
          total++;
          if (obs_addr[i] !== model_addr(i) || obs_data[i] !== model_data(i)) begin
            bad++;
            $display("FAIL rand_word_%0d_%0d: %h@%h required %h@%h", r, i, obs_data[i], obs_addr[i], model_data(i), model_addr(i));
          end
        end
      end
    end
  endtask

  task automatic test_full();
    fill_random(SIZE);
    run_load(SIZE, 0);
    total++;
    if (obs_addr.size() != SIZE) begin
      bad++;
      $display("FAIL full_count: writes=%0d required=%0d", obs_addr.size(), SIZE);
    end else begin
      total++;
      if (obs_addr[SIZE-1] !== BASE_ADDR + 32'(4 * (SIZE - 1))) begin
        bad++;
        $display("FAIL full_last_addr: addr=%h required=%h", obs_addr[SIZE-1], BASE_ADDR + 32'(4 * (SIZE - 1)));
      end
      for (int i = 0; i < SIZE; i++) begin
        total++;
        if (obs_data[i] !== model_data(i)) begin
          bad++;
          $display("FAIL full_word%0d: data=%h required=%h", i, obs_data[i], model_data(i));
        end
      end
    end
    total++;
    if (done !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL full_done: done=%b err=%b required 1 0", done, err);
    end
  endtask

`ifdef INST_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] ck;
    for (int r = 0; r < 2; r++) begin
      ck = (r == 0) ? 8'h0F : 8'h00;
      stim = '{8'h01, 8'h02, 8'h04, 8'h08};
      clear_obs();
      pulse_start(16'd1);
      for (int j = 0; j < 4; j++) send_byte(stim[j], 0);
      send_byte(ck, 0);
      wait_done();
      total++;
      if (chk_err !== ((ck != model_csum()) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL chk_err_%0d: chk=%b required=%b", r, chk_err, (ck != model_csum()));
      end
      total++;
      if (obs_addr.size() != 1 || obs_data[0] !== 32'h0804_0201 || obs_addr[0] !== BASE_ADDR) begin
        bad++;
        $display("FAIL chk_word_%0d: writes=%0d data=%h required 1 08040201", r, obs_addr.size(), obs_data[0]);
      end
    end
  endtask
`else
  task automatic test_checksum();
    fill_random(1);
    run_load(1, 0);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || chk_err !== 1'b0 || obs_addr.size() != 1) begin
      bad++;
      $display("FAIL no_trailer: rdy=%b busy=%b chk=%b writes=%0d required 0 0 0 1",
               in_ready, busy, chk_err, obs_addr.size());
    end
    in_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_stall();
    test_reset_mid();
    test_random();
    test_full();
    test_checksum();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Instruction-memory loader: the write side of the instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instructions and issues single-cycle word writes at byte addresses matching the fetch PC convention (word index = address / 4). It sits between the host/debug byte link and the instruction memory's write port, and is used to program code before the core is released from reset.

## Interface
- `SIZE`, 1024: instruction memory depth in words; upper bound on the load length.
- `BASE_ADDR`, 0: byte address of the first written word; must be 4-aligned.
- `clk`  in  1: clock, all state on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle request to begin a load; sampled only when not busy.
- `num_words`  in  16: number of instructions to load, latched on accepted `start`.
- `in_data`  in  8: stream byte.
- `in_valid`  in  1: `in_data` valid.
- `in_ready`  out  1: loader accepts a byte this cycle.
- `mem_we`  out  1: instruction memory write strobe, one cycle per word.
- `mem_addr`  out  `WORD`: byte address of the write.
- `mem_wdata`  out  `INST_SIZE`: instruction word written.
- `busy`  out  1: load in progress.
- `done`  out  1: sticky; last load finished (successfully or with error).
- `err`  out  1: sticky; last `start` had illegal length.
- `chk_err`  out  1: sticky; checksum mismatch (0 when checksum compiled out).

## Operation
- States: IDLE, RECV, WRITE, CHECK (checksum build only).
- IDLE: `in_ready`=0. On `start`: clear `done`, `err`, `chk_err`; if `num_words` is 0 or > `SIZE`, set `err`=1 and `done`=1, stay IDLE; else latch length, word index=0, byte count=0, go RECV.
- RECV: `in_ready`=1. Byte accepted when `in_valid & in_ready`. Byte k (0..3) of a word lands in bits [8k+7:8k]. On the 4th accepted byte go WRITE.
- WRITE: `in_ready`=0; `mem_we`=1; `mem_addr` = `BASE_ADDR` + 4*word index; `mem_wdata` = assembled word. Then if word index = length-1: go CHECK (if compiled in) else IDLE with `done`=1; otherwise increment word index, go RECV.
- `busy`=1 in RECV, WRITE, CHECK.
- `start` while busy is ignored; `num_words` changes after latch have no effect.
- `in_valid` low in RECV stalls indefinitely; partial word is held.
- Bytes presented while `in_ready`=0 are not consumed.
- Address arithmetic is `WORD` wide; `BASE_ADDR` + 4*(SIZE-1) never wraps for legal parameters.

## Timing
- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `err`=0, `chk_err`=0; state IDLE.
- `start` at cycle n -> `busy`/`in_ready`=1 at n+1 (legal length); `err`/`done`=1 at n+1 (illegal).
- 4th byte accepted at cycle m -> `mem_we`=1 during cycle m+1; `in_ready` drops for that cycle.
- Full-rate throughput: 5 cycles per word.
- `done` rises the cycle after the final WRITE (or after CHECK byte accepted); stays high until next accepted `start`.
- `mem_addr`/`mem_wdata` are registered and hold last values when `mem_we`=0.
- Reset mid-load: immediate return to IDLE, partial word discarded, no write issued, all flags cleared.

## Configuration
- `INST_LOADER_CHECKSUM_EN` defined: after the final WRITE, enter CHECK with `in_ready`=1; accept one byte; compare with XOR of all data bytes of this load; mismatch sets `chk_err`=1; then IDLE with `done`=1. Written words are not rolled back.
- Undefined: no CHECK state, no trailing byte consumed, `chk_err` tied to 0.

## Test plan
- Reset then `start` with `num_words`=2, bytes 13 05 00 91 EF BE AD DE at full rate -> writes 0x91000513 @ 0x0 then 0xDEADBEEF @ 0x4, `done`=1, `err`=0.
- `num_words`=0 and `num_words`=SIZE+1 -> `err`=1, `done`=1 next cycle, no `mem_we`, `busy`=0.
- `num_words`=3 with `in_valid` toggling every other cycle and `BASE_ADDR`=0x100 -> writes at 0x100, 0x104, 0x108 with correct words; `start` pulsed mid-load is ignored.
- `rst_n` low after 2 bytes of word 1 -> all outputs reset, no write; new load after release writes from `BASE_ADDR`.
- `SIZE` words loaded -> last write at `BASE_ADDR`+4*(SIZE-1), then `done`=1.
- With `INST_LOADER_CHECKSUM_EN`: load 1 word 01 02 04 08, checksum 0x0F -> `chk_err`=0; checksum 0x00 -> `chk_err`=1, word still written.
